// File: rtl/image_resize_avg_if.sv
// Frame-buffer read port and uart_tx byte port seen by image_resize_avg.
// master: the resizer (issues reads, drives bytes); slave: memory + UART side.
interface image_resize_avg_if;
  logic        start_resize;
  logic [22:0] read_addr_resize;
  logic [7:0]  Read_DATA2;
  logic [7:0]  uart_tx;
  logic        uart_trmt;
  logic        tx_done;

  modport master (output start_resize, read_addr_resize, uart_tx, uart_trmt,
                  input  Read_DATA2, tx_done);
  modport slave  (input  start_resize, read_addr_resize, uart_tx, uart_trmt,
                  output Read_DATA2, tx_done);
endinterface

// File: rtl/image_resize_avg.sv
// image_resize_avg: streams one IMG_W x IMG_H 8-bit frame, floor-averages each
// (IMG_W/OUT_W) x (IMG_H/OUT_H) block into an OUT_H x OUT_W thumbnail and sends
// it row-major over a uart_tx byte port.
// Optional macro IMAGE_RESIZE_UART_HEADER_EN: prefix the bytes with 0xA5, 0x5A.
module image_resize_avg #(
  parameter int          IMG_W     = 640,
  parameter int          IMG_H     = 480,
  parameter int          OUT_W     = 32,
  parameter int          OUT_H     = 32,
  parameter logic [22:0] BASE_ADDR = 23'd0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               KEY_2,
  image_resize_avg_if.master bus,
  output logic               avg_done,
  output logic               done,
  output logic               triggered
);
  localparam int BW      = IMG_W / OUT_W;
  localparam int BH      = IMG_H / OUT_H;
  localparam int DIVISOR = BW * BH;
  localparam int NOUT    = OUT_W * OUT_H;
`ifdef IMAGE_RESIZE_UART_HEADER_EN
  localparam int HDR_N   = 2;
`else
  localparam int HDR_N   = 0;
`endif
  localparam int NTX     = NOUT + HDR_N;

  // Reciprocal multiply: with SHIFT = bits(numerator) + ceil(log2 D) and
  // MULT = ceil(2^SHIFT / D), (n*MULT)>>SHIFT == floor(n/D) for every n that
  // fits in ACC_W bits.
  localparam int ACC_W = $clog2(DIVISOR * 255 + 1);
  localparam int SHIFT = ACC_W + $clog2(DIVISOR);
  localparam int MUL_W = ACC_W + 2;
  localparam int PRD_W = ACC_W + MUL_W;
  localparam longint MULT_L = ((longint'(1) << SHIFT) + longint'(DIVISOR - 1)) / longint'(DIVISOR);
  localparam logic [MUL_W-1:0] MULT = MUL_W'(MULT_L);

  localparam int CX_W = (BW    > 1) ? $clog2(BW)    : 1;
  localparam int BX_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int RY_W = (BH    > 1) ? $clog2(BH)    : 1;
  localparam int BY_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int OI_W = (NOUT  > 1) ? $clog2(NOUT)  : 1;
  localparam int TI_W = (NTX   > 1) ? $clog2(NTX)   : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_READ    = 3'd1;
  localparam logic [2:0] S_DIV     = 3'd2;
  localparam logic [2:0] S_TX_LOAD = 3'd3;
  localparam logic [2:0] S_TX_WAIT = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]       r_state;
  logic             r_key_s1, r_key_s2, r_key_d;
  logic [CX_W-1:0]  r_cx;
  logic [BX_W-1:0]  r_bx, r_bxq, r_k;
  logic [RY_W-1:0]  r_ry;
  logic [BY_W-1:0]  r_by;
  logic [22:0]      r_lin, r_addr_hold;
  logic             r_vld, r_ign;
  logic [OI_W-1:0]  r_wptr;
  logic [TI_W-1:0]  r_tidx;
  logic [7:0]       r_tx_hold;
  logic             r_avg_done, r_done, r_trig;
  logic [ACC_W-1:0] r_acc [OUT_W];
  logic [7:0]       r_out [NOUT];

  logic             w_fall, w_start, w_row_end, w_band_end, w_div_go, w_div_en;
  logic [22:0]      w_addr;
  logic [ACC_W-1:0] w_acc_sel;
  logic [PRD_W-1:0] w_prod;
  logic [7:0]       w_q, w_byte;
  logic [OI_W-1:0]  w_oidx;

  assign w_fall     = r_key_d & ~r_key_s2;
  assign w_start    = w_fall & ((r_state == S_IDLE) | (r_state == S_DONE));
  assign w_row_end  = (r_bx == BX_W'(OUT_W - 1)) && (r_cx == CX_W'(BW - 1));
  assign w_band_end = w_row_end && (r_ry == RY_W'(BH - 1));
  assign w_addr     = BASE_ADDR + r_lin;
  // Only stall DIV if the lane it is about to divide still has a pixel in flight.
  assign w_div_go   = !(r_vld && (r_bxq == r_k));
  assign w_div_en   = (r_state == S_DIV) && w_div_go;
  assign w_acc_sel  = r_acc[r_k];
  assign w_prod     = PRD_W'(w_acc_sel) * PRD_W'(MULT);
  assign w_q        = 8'(w_prod >> SHIFT);

  // Next byte for the UART: optional header, then the thumbnail row-major.
  always_comb begin
    w_oidx = OI_W'(r_tidx - TI_W'(HDR_N));
    w_byte = r_out[w_oidx];
`ifdef IMAGE_RESIZE_UART_HEADER_EN
    if (r_tidx == TI_W'(0))      w_byte = 8'hA5;
    else if (r_tidx == TI_W'(1)) w_byte = 8'h5A;
`endif
  end

  assign bus.start_resize     = (r_state == S_READ);
  assign bus.read_addr_resize = bus.start_resize ? w_addr : r_addr_hold;
  assign bus.uart_trmt        = (r_state == S_TX_LOAD);
  assign bus.uart_tx          = bus.uart_trmt ? w_byte : r_tx_hold;
  assign avg_done             = r_avg_done;
  assign done                 = r_done;
  assign triggered            = r_trig;

  // Two-flop synchronizer plus delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_key_s1 <= 1'b1;
      r_key_s2 <= 1'b1;
      r_key_d  <= 1'b1;
    end else begin
      r_key_s1 <= KEY_2;
      r_key_s2 <= r_key_s1;
      r_key_d  <= r_key_s2;
    end
  end

  // Per-column-block accumulators: add returned pixels, clear as DIV consumes.
  always_ff @(posedge clk) begin
    for (int i = 0; i < OUT_W; i++) begin
      if (rst)
        r_acc[i] <= '0;
      else if (w_div_en && (r_k == BX_W'(i)))
        r_acc[i] <= '0;
      else if (r_vld && (r_bxq == BX_W'(i)))
        r_acc[i] <= r_acc[i] + ACC_W'(bus.Read_DATA2);
    end
  end

  // Thumbnail memory; survives reset and is only rewritten by a new run.
  always_ff @(posedge clk) begin
    if (!rst && w_div_en) r_out[r_wptr] <= w_q;
  end

  // Control FSM: read pass with per-band divide, then UART transmit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cx <= '0; r_bx <= '0; r_bxq <= '0; r_k <= '0; r_ry <= '0; r_by <= '0;
      r_lin <= '0; r_addr_hold <= '0; r_vld <= 1'b0; r_ign <= 1'b0;
      r_wptr <= '0; r_tidx <= '0; r_tx_hold <= '0;
      r_avg_done <= 1'b0; r_done <= 1'b0; r_trig <= 1'b0;
    end else begin
      r_vld <= (r_state == S_READ);
      r_bxq <= r_bx;
      case (r_state)
        S_IDLE, S_DONE: if (w_start) begin
          r_state <= S_READ;
          r_cx <= '0; r_bx <= '0; r_ry <= '0; r_by <= '0; r_k <= '0;
          r_lin <= '0; r_wptr <= '0; r_tidx <= '0;
          r_avg_done <= 1'b0; r_done <= 1'b0; r_trig <= 1'b1;
        end
        S_READ: begin
          r_lin       <= r_lin + 23'd1;
          r_addr_hold <= w_addr;
          if (r_cx == CX_W'(BW - 1)) begin
            r_cx <= '0;
            r_bx <= w_row_end ? '0 : r_bx + BX_W'(1);
          end else begin
            r_cx <= r_cx + CX_W'(1);
          end
          if (w_row_end) r_ry <= w_band_end ? '0 : r_ry + RY_W'(1);
          if (w_band_end) begin
            r_state <= S_DIV;
            r_k     <= '0;
          end
        end
        S_DIV: if (w_div_go) begin
          r_wptr <= r_wptr + OI_W'(1);
          if (r_k == BX_W'(OUT_W - 1)) begin
            r_k <= '0;
            if (r_by == BY_W'(OUT_H - 1)) begin
              r_state    <= S_TX_LOAD;
              r_avg_done <= 1'b1;
              r_tidx     <= '0;
            end else begin
              r_by    <= r_by + BY_W'(1);
              r_state <= S_READ;
            end
          end else begin
            r_k <= r_k + BX_W'(1);
          end
        end
        S_TX_LOAD: begin
          r_tx_hold <= w_byte;
          r_ign     <= 1'b1;
          r_state   <= S_TX_WAIT;
        end
        S_TX_WAIT: begin
          // tx_done from the previous byte may still read high right after trmt.
          if (r_ign) r_ign <= 1'b0;
          else if (bus.tx_done) begin
            if (r_tidx == TI_W'(NTX - 1)) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_trig  <= 1'b0;
            end else begin
              r_tidx  <= r_tidx + TI_W'(1);
              r_state <= S_TX_LOAD;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_image_resize_avg.sv
// Bench for image_resize_avg on a reduced 80x30 frame (4x2 thumbnail, same
// 20x15 block size). Frame memory and UART are behavioural models; expected
// bytes come from a plain floor(sum/300) model and are checked via a queue.
module tb_image_resize_avg;
  localparam int IMG_W = 80, IMG_H = 30, OUT_W = 4, OUT_H = 2;
  localparam int BW = IMG_W / OUT_W, BH = IMG_H / OUT_H;
  localparam int NPIX = IMG_W * IMG_H, NOUT = OUT_W * OUT_H;
  localparam logic [22:0] BASE = 23'd100;
`ifdef IMAGE_RESIZE_UART_HEADER_EN
  localparam int HDR = 2;
`else
  localparam int HDR = 0;
`endif
  localparam int TOTAL = NOUT + HDR;
  localparam int TX_LAT = 6;
  localparam int LIMIT = 12000;

  logic clk = 1'b0, rst = 1'b1, KEY_2 = 1'b1;
  logic avg_done, done, triggered;
  always #5 clk = ~clk;

  image_resize_avg_if bus();
  image_resize_avg #(.IMG_W(IMG_W), .IMG_H(IMG_H), .OUT_W(OUT_W), .OUT_H(OUT_H),
                     .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .KEY_2(KEY_2), .bus(bus),
    .avg_done(avg_done), .done(done), .triggered(triggered));

  int errors = 0, checks = 0;
  logic [7:0] mem [NPIX];
  logic [7:0] q [$];
  logic [7:0] cap [NOUT];
  int n_reads, addr_bad, n_trmt, inflight_bad, exp_idx, busy;

  typedef struct {
    int pat; int hold; int mid; bit chk; logic [7:0] e00; logic [7:0] e01;
  } vec_t;
  vec_t tbl [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Frame memory: one-cycle read latency.
  initial bus.Read_DATA2 = 8'd0;
  always @(posedge clk) begin
    int a;
    a = int'(bus.read_addr_resize) - int'(BASE);
    if (bus.start_resize && a >= 0 && a < NPIX) bus.Read_DATA2 <= mem[a];
  end

  // UART: tx_done drops on trmt, returns high TX_LAT cycles later.
  initial bus.tx_done = 1'b1;
  always @(posedge clk) begin
    if (rst) begin
      busy <= 0; bus.tx_done <= 1'b1;
    end else if (bus.uart_trmt) begin
      busy <= TX_LAT; bus.tx_done <= 1'b0;
    end else if (busy > 0) begin
      busy <= busy - 1;
      if (busy == 1) bus.tx_done <= 1'b1;
    end
  end

  // Monitor: address sequence and scoreboard on each strobe.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst) begin
      if (bus.start_resize) begin
        n_reads++;
        if (bus.read_addr_resize !== BASE + 23'(exp_idx)) addr_bad++;
        exp_idx++;
      end
      if (bus.uart_trmt) begin
        n_trmt++;
        if (bus.tx_done !== 1'b1) inflight_bad++;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe: byte %0d got %0d expected none", n_trmt, bus.uart_tx);
        end else begin
          e = q.pop_front();
          if (bus.uart_tx !== e) begin
            errors++;
            $display("FAIL tx_byte %0d: got %0d expected %0d", n_trmt - 1, bus.uart_tx, e);
          end
        end
        if (n_trmt - 1 - HDR >= 0 && n_trmt - 1 - HDR < NOUT) cap[n_trmt - 1 - HDR] = bus.uart_tx;
      end
    end
  end

  task automatic fill(input int pat);
    for (int y = 0; y < IMG_H; y++)
      for (int x = 0; x < IMG_W; x++) begin
        int idx = y * IMG_W + x;
        case (pat)
          0: mem[idx] = 8'(idx % 256);
          1: mem[idx] = 8'd255;
          2: mem[idx] = 8'd0;
          3: if (x == 0 && y == 0) mem[idx] = 8'd255;
             else if (x >= BW && x < 2 * BW && y < BH) mem[idx] = (x == BW + 5 && y == 3) ? 8'd0 : 8'd255;
             else mem[idx] = 8'd0;
          default: mem[idx] = 8'($urandom_range(0, 255));
        endcase
      end
  endtask

  task automatic clear_model();
    q.delete();
    n_reads = 0; addr_bad = 0; n_trmt = 0; inflight_bad = 0; exp_idx = 0;
  endtask

  task automatic push_expected();
    int sum;
`ifdef IMAGE_RESIZE_UART_HEADER_EN
    q.push_back(8'hA5);
    q.push_back(8'h5A);
`endif
    for (int by = 0; by < OUT_H; by++)
      for (int bx = 0; bx < OUT_W; bx++) begin
        sum = 0;
        for (int yy = 0; yy < BH; yy++)
          for (int xx = 0; xx < BW; xx++)
            sum += int'(mem[(by * BH + yy) * IMG_W + bx * BW + xx]);
        q.push_back(8'(sum / (BW * BH)));
      end
  endtask

  task automatic run(input vec_t v);
    int cyc;
    fill(v.pat);
    clear_model();
    push_expected();
    cyc = 0;
    while (cyc < LIMIT) begin
      @(negedge clk);
      KEY_2 = (cyc < v.hold || (v.mid > 0 && cyc >= v.mid && cyc < v.mid + 4)) ? 1'b0 : 1'b1;
      if (cyc == 10) begin
        check("run_triggered", 32'(triggered), 32'd1);
        check("run_avg_done_cleared", 32'(avg_done), 32'd0);
        check("run_done_cleared", 32'(done), 32'd0);
      end
      if (cyc > 10 && done === 1'b1) break;
      cyc++;
    end
    KEY_2 = 1'b1;
    if (cyc >= LIMIT) begin
      errors++; checks++;
      $display("FAIL timeout: pattern %0d got no done after %0d cycles", v.pat, LIMIT);
    end
    check("done_level", 32'(done), 32'd1);
    check("triggered_low", 32'(triggered), 32'd0);
    check("avg_done_level", 32'(avg_done), 32'd1);
    check("read_count", 32'(n_reads), 32'(NPIX));
    check("addr_errors", 32'(addr_bad), 32'd0);
    check("strobe_count", 32'(n_trmt), 32'(TOTAL));
    check("strobe_in_flight", 32'(inflight_bad), 32'd0);
    check("queue_empty", 32'(q.size()), 32'd0);
    if (v.chk) begin
      check("tbl_out00", 32'(cap[0]), 32'(v.e00));
      check("tbl_out01", 32'(cap[1]), 32'(v.e01));
    end
    repeat (5) @(negedge clk);
  endtask

  initial begin
    tbl[0] = '{0,    4,    0, 1'b1, 8'd122, 8'd121};
    tbl[1] = '{1, 1000, 1500, 1'b1, 8'd255, 8'd255};
    tbl[2] = '{2,    4,    0, 1'b1, 8'd0,   8'd0};
    tbl[3] = '{3,    4,    0, 1'b1, 8'd0,   8'd254};
    tbl[4] = '{4,    4,    0, 1'b0, 8'd0,   8'd0};
    clear_model();

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_start", 32'(bus.start_resize), 32'd0);
    check("rst_addr", 32'(bus.read_addr_resize), 32'd0);
    check("rst_trmt", 32'(bus.uart_trmt), 32'd0);
    check("rst_flags", {29'd0, avg_done, done, triggered}, 32'd0);

    // Trigger latency: sync takes two edges, READ begins on the third.
    fill(2);
    clear_model();
    KEY_2 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("lat_start_pre", 32'(bus.start_resize), 32'd0);
    @(negedge clk);
    check("lat_start", 32'(bus.start_resize), 32'd1);
    check("lat_addr", 32'(bus.read_addr_resize), 32'(BASE));
    KEY_2 = 1'b1;

    // Reset mid-READ aborts the run.
    repeat (500) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_start", 32'(bus.start_resize), 32'd0);
    check("abort_trig", 32'(triggered), 32'd0);
    check("abort_addr", 32'(bus.read_addr_resize), 32'd0);
    rst = 1'b0;
    clear_model();
    repeat (50) @(negedge clk);
    check("abort_no_reads", 32'(n_reads), 32'd0);
    check("abort_no_strobes", 32'(n_trmt), 32'd0);

    // Table: full runs, restarted from BASE after the abort.
    for (int i = 0; i < 5; i++) run(tbl[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
